// File: rtl/mprj_pad_ctrl.sv
// User-project pad ring controller: per-pad mode words, registered pad-cell
// controls, filtered input path with sticky edge flags, and output-enable turnaround.
module mprj_pad_ctrl #(
  parameter int NUM_PADS = 38,
  parameter int ADDR_W   = 6,
  parameter int FILT_W   = 4,
  parameter int TURN_CYC = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  cfg_we,
  input  logic [ADDR_W-1:0]     cfg_addr,
  input  logic [3:0]            cfg_wdata,
  output logic                  cfg_ready,
  output logic                  cfg_err,
  input  logic [FILT_W-1:0]     filt_len,
  input  logic [NUM_PADS-1:0]   core_out,
  output logic [NUM_PADS-1:0]   core_in,
  input  logic [NUM_PADS-1:0]   pad_in,
  output logic [NUM_PADS-1:0]   pad_out,
  output logic [NUM_PADS-1:0]   pad_oen,
  output logic [NUM_PADS-1:0]   pad_ren,
  output logic [3*NUM_PADS-1:0] pad_dm,
  input  logic [NUM_PADS-1:0]   edge_clr,
  output logic [NUM_PADS-1:0]   edge_rise,
  output logic [NUM_PADS-1:0]   edge_fall,
  output logic                  irq
);

  localparam logic [2:0]        DM_IN     = 3'b001;
  localparam logic [2:0]        DM_PU     = 3'b010;
  localparam logic [2:0]        DM_PD     = 3'b011;
  localparam logic [2:0]        DM_OUT    = 3'b110;
  localparam logic [3:0]        TURN_LOAD = 4'(TURN_CYC - 1);
  localparam logic [ADDR_W:0]   NPADS     = (ADDR_W + 1)'(NUM_PADS);

  typedef enum logic {IDLE = 1'b0, TURN = 1'b1} state_t;

  state_t                state;
  logic [3:0]            turn_cnt;
  logic [NUM_PADS-1:0]   turn_mask;
  logic [NUM_PADS-1:0]   filt_en;
  logic [NUM_PADS-1:0]   sync1;
  logic [NUM_PADS-1:0]   sync2;
  logic [FILT_W-1:0]     cnt [NUM_PADS];

  logic                  accept;
  logic                  addr_ok;
  logic                  start_turn;
  logic [2:0]            wr_dm;
  logic [NUM_PADS-1:0]   wr_hit;
  logic [NUM_PADS-1:0]   is_out;
  logic [NUM_PADS-1:0]   upd;

  // Unsupported DM codes collapse to plain input.
  function automatic logic [2:0] legal_dm(input logic [2:0] dm);
    case (dm)
      DM_IN, DM_PU, DM_PD, DM_OUT: legal_dm = dm;
      default:                     legal_dm = DM_IN;
    endcase
  endfunction

  // Write decode and per-pad filter expiry.
  always_comb begin
    accept  = cfg_we & cfg_ready;
    addr_ok = ({1'b0, cfg_addr} < NPADS);
    wr_dm   = legal_dm(cfg_wdata[2:0]);
    wr_hit  = '0;
    is_out  = '0;
    upd     = '0;
    for (int k = 0; k < NUM_PADS; k++) begin
      is_out[k] = (pad_dm[3*k +: 3] == DM_OUT);
      wr_hit[k] = accept && addr_ok && (cfg_addr == ADDR_W'(k));
      // ">=" so a shortened filter length fires on the next compare
      upd[k]    = (sync2[k] != core_in[k]) &&
                  (cnt[k] >= (filt_en[k] ? filt_len : FILT_W'(0)));
    end
    start_turn = (wr_dm == DM_OUT) && |(wr_hit & ~is_out);
  end

  // Mode registers, pad controls and the turnaround FSM.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      turn_cnt  <= 4'd0;
      turn_mask <= '0;
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
      pad_dm    <= {NUM_PADS{DM_IN}};
      filt_en   <= '0;
      pad_oen   <= '1;
      pad_ren   <= '1;
    end else begin
      cfg_err <= accept && !addr_ok;
      for (int k = 0; k < NUM_PADS; k++) begin
        if (wr_hit[k]) begin
          pad_dm[3*k +: 3] <= wr_dm;
          filt_en[k]       <= cfg_wdata[3];
          pad_ren[k]       <= (wr_dm != DM_PU);
          // Entering output mode keeps the pad tristated until the turnaround ends.
          if (wr_dm != DM_OUT) begin
            pad_oen[k] <= 1'b1;
          end else begin
            pad_oen[k] <= pad_oen[k];
          end
        end
      end
      case (state)
        IDLE: begin
          if (start_turn) begin
            state     <= TURN;
            turn_cnt  <= TURN_LOAD;
            turn_mask <= wr_hit;
            cfg_ready <= 1'b0;
          end
        end
        TURN: begin
          if (turn_cnt == 4'd0) begin
            state     <= IDLE;
            cfg_ready <= 1'b1;
            turn_mask <= '0;
            for (int k = 0; k < NUM_PADS; k++) begin
              if (turn_mask[k]) pad_oen[k] <= 1'b0;
            end
          end else begin
            turn_cnt <= turn_cnt - 4'd1;
          end
        end
        default: begin
          state     <= IDLE;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  // Synchroniser, glitch filter, sticky edges, irq and output data.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync1     <= '0;
      sync2     <= '0;
      core_in   <= '0;
      edge_rise <= '0;
      edge_fall <= '0;
      irq       <= 1'b0;
      pad_out   <= '0;
      for (int k = 0; k < NUM_PADS; k++) cnt[k] <= '0;
    end else begin
      sync1     <= pad_in;
      sync2     <= sync1;
      pad_out   <= core_out;
      irq       <= (|edge_rise) | (|edge_fall);
      core_in   <= core_in ^ upd;
      edge_rise <= (edge_rise & ~edge_clr) | (upd & sync2);
      edge_fall <= (edge_fall & ~edge_clr) | (upd & ~sync2);
      for (int k = 0; k < NUM_PADS; k++) begin
        if (sync2[k] == core_in[k] || upd[k]) begin
          cnt[k] <= '0;
        end else begin
          cnt[k] <= cnt[k] + FILT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mprj_pad_ctrl.sv
// Bench for mprj_pad_ctrl: table of config writes, directed filter/turnaround
// sequences, then random traffic against a window/timestamp reference model.
module tb_mprj_pad_ctrl;
  localparam int NP = 38;
  localparam int AW = 6;
  localparam int FW = 4;
  localparam int TC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [3:0]    cfg_wdata;
  logic          cfg_ready, cfg_err, irq;
  logic [FW-1:0] filt_len;
  logic [NP-1:0] core_out, core_in, pad_in, pad_out, pad_oen, pad_ren;
  logic [NP-1:0] edge_clr, edge_rise, edge_fall;
  logic [3*NP-1:0] pad_dm;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mprj_pad_ctrl #(.NUM_PADS(NP), .ADDR_W(AW), .FILT_W(FW), .TURN_CYC(TC)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .filt_len(filt_len), .core_out(core_out), .core_in(core_in), .pad_in(pad_in),
    .pad_out(pad_out), .pad_oen(pad_oen), .pad_ren(pad_ren), .pad_dm(pad_dm),
    .edge_clr(edge_clr), .edge_rise(edge_rise), .edge_fall(edge_fall), .irq(irq)
  );

  // Reference model state
  logic [2:0]    m_dm [NP];
  logic [NP-1:0] m_fen, m_oen, m_ren, m_pad_out, m_core_in, m_rise, m_fall;
  logic          m_irq, m_err, m_ready, m_pend;
  int            m_turn_pad, m_turn_done;
  int            cyc = 0;
  logic [NP-1:0] hist [20];   // hist[0] = pad_in at the previous edge

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    logic [NP-1:0] upd;
    logic [2:0]    d;
    logic          acc, diff;
    int            len, a;
    if (rst) begin
      for (int k = 0; k < NP; k++) m_dm[k] = 3'b001;
      m_fen = '0; m_oen = '1; m_ren = '1; m_pad_out = '0; m_core_in = '0;
      m_rise = '0; m_fall = '0; m_irq = 1'b0; m_err = 1'b0; m_ready = 1'b1; m_pend = 1'b0;
      for (int i = 0; i < 20; i++) hist[i] = '0;
    end else begin
      m_irq = (|m_rise) || (|m_fall);
      // A pad input is accepted once Leff+1 consecutive synchronised samples differ.
      for (int k = 0; k < NP; k++) begin
        len  = m_fen[k] ? int'(filt_len) : 0;
        diff = 1'b1;
        for (int j = 1; j <= len + 1; j++) if (hist[j][k] == m_core_in[k]) diff = 1'b0;
        upd[k] = diff;
      end
      m_rise = (m_rise & ~edge_clr) | (upd & ~m_core_in);
      m_fall = (m_fall & ~edge_clr) | (upd & m_core_in);
      m_core_in = m_core_in ^ upd;
      m_pad_out = core_out;
      acc   = cfg_we && m_ready;
      m_err = acc && (int'(cfg_addr) >= NP);
      if (m_pend && cyc == m_turn_done) begin
        m_oen[m_turn_pad] = 1'b0;
        m_ready = 1'b1;
        m_pend  = 1'b0;
      end
      if (acc && int'(cfg_addr) < NP) begin
        a = int'(cfg_addr);
        d = (cfg_wdata[2:0] inside {3'b001, 3'b010, 3'b011, 3'b110}) ? cfg_wdata[2:0] : 3'b001;
        if (d == 3'b110 && m_dm[a] != 3'b110) begin
          m_pend = 1'b1; m_turn_pad = a; m_turn_done = cyc + TC; m_ready = 1'b0;
        end else if (d != 3'b110) begin
          m_oen[a] = 1'b1;
        end
        m_dm[a] = d; m_fen[a] = cfg_wdata[3]; m_ren[a] = (d != 3'b010);
      end
      for (int i = 19; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = pad_in;
    end
    cyc++;
  endtask

  task automatic check_all();
    logic [3*NP-1:0] flat;
    for (int k = 0; k < NP; k++) flat[3*k +: 3] = m_dm[k];
    chk("pad_dm", pad_dm, flat);
    chk("pad_oen", pad_oen, m_oen);
    chk("pad_ren", pad_ren, m_ren);
    chk("pad_out", pad_out, m_pad_out);
    chk("core_in", core_in, m_core_in);
    chk("edge_rise", edge_rise, m_rise);
    chk("edge_fall", edge_fall, m_fall);
    chk("irq", irq, m_irq);
    chk("cfg_ready", cfg_ready, m_ready);
    chk("cfg_err", cfg_err, m_err);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic write_cfg(input int a, input logic [3:0] w);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_wdata = w;
    tick();
    cfg_we = 1'b0;
  endtask

  typedef struct {
    int         addr;
    logic [3:0] wdata;
    logic [2:0] exp_dm;
    logic       exp_ren;
    logic       exp_oen;
    logic       exp_err;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{2,  4'b0111, 3'b001, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{3,  4'b0010, 3'b010, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{4,  4'b0011, 3'b011, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{40, 4'b0010, 3'b001, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{7,  4'b0000, 3'b001, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{8,  4'b0101, 3'b001, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{5,  4'b1001, 3'b001, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{63, 4'b0110, 3'b001, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{37, 4'b0010, 3'b010, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{38, 4'b0001, 3'b001, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{3,  4'b0001, 3'b001, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; filt_len = '0;
    core_out = '0; pad_in = '0; edge_clr = '0;

    // Reset
    tick(); tick();
    rst = 1'b0;
    chk("rst_dm", pad_dm, {NP{3'b001}});
    chk("rst_oen", pad_oen, {NP{1'b1}});
    chk("rst_ren", pad_ren, {NP{1'b1}});
    chk("rst_ready", cfg_ready, 1'b1);
    chk("rst_core_in", core_in, '0);

    // Table of single config writes
    for (int i = 0; i < 11; i++) begin
      write_cfg(tbl[i].addr, tbl[i].wdata);
      chk("tbl_err", cfg_err, tbl[i].exp_err);
      if (!tbl[i].exp_err) begin
        chk("tbl_dm", pad_dm[3*tbl[i].addr +: 3], tbl[i].exp_dm);
        chk("tbl_ren", pad_ren[tbl[i].addr], tbl[i].exp_ren);
        chk("tbl_oen", pad_oen[tbl[i].addr], tbl[i].exp_oen);
      end
      tick();
      chk("tbl_err_pulse", cfg_err, 1'b0);
    end

    // Filter: short glitch on pad 5 is rejected
    filt_len = 4'd3;
    pad_in[5] = 1'b1;
    repeat (3) tick();
    pad_in[5] = 1'b0;
    repeat (8) tick();
    chk("glitch_core_in", core_in[5], 1'b0);
    chk("glitch_rise", edge_rise[5], 1'b0);

    // Filter: persistent rise lands at edge 6, irq one cycle later
    pad_in[5] = 1'b1;
    repeat (5) tick();
    chk("rise_e5", core_in[5], 1'b0);
    tick();
    chk("rise_e6", core_in[5], 1'b1);
    chk("rise_flag", edge_rise[5], 1'b1);
    chk("irq_lag", irq, 1'b0);
    tick();
    chk("irq_set", irq, 1'b1);

    // Fall coincides with edge_clr: set wins
    pad_in[5] = 1'b0;
    repeat (5) tick();
    edge_clr[5] = 1'b1;
    tick();
    chk("setwins_fall", edge_fall[5], 1'b1);
    chk("clr_rise", edge_rise[5], 1'b0);
    tick();
    edge_clr[5] = 1'b0;
    chk("clr_fall", edge_fall[5], 1'b0);
    tick(); tick();
    chk("irq_clear", irq, 1'b0);

    // Turnaround on pad 0, with a dropped write to pad 1 at N+2
    write_cfg(0, 4'b0110);
    chk("turn_dm", pad_dm[2:0], 3'b110);
    chk("turn_n_oen", pad_oen[0], 1'b1);
    chk("turn_n_ready", cfg_ready, 1'b0);
    tick();
    chk("turn_n1_oen", pad_oen[0], 1'b1);
    write_cfg(1, 4'b0010);
    chk("drop_ren", pad_ren[1], 1'b1);
    chk("drop_ready", cfg_ready, 1'b0);
    tick();
    chk("turn_n3_oen", pad_oen[0], 1'b1);
    chk("turn_n3_ready", cfg_ready, 1'b0);
    tick();
    chk("turn_n4_oen", pad_oen[0], 1'b0);
    chk("turn_n4_ready", cfg_ready, 1'b1);
    chk("drop_err", cfg_err, 1'b0);

    // Rewrite output mode: no new turnaround
    write_cfg(0, 4'b1110);
    chk("rewrite_ready", cfg_ready, 1'b1);
    chk("rewrite_oen", pad_oen[0], 1'b0);

    // Mode exit with pull-up
    write_cfg(0, 4'b0010);
    chk("exit_oen", pad_oen[0], 1'b1);
    chk("exit_ren", pad_ren[0], 1'b0);

    // Reset at N+2 of a turnaround
    write_cfg(6, 4'b0110);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstturn_oen", pad_oen, {NP{1'b1}});
    chk("rstturn_ready", cfg_ready, 1'b1);
    chk("rstturn_dm", pad_dm[20:18], 3'b001);
    repeat (4) tick();
    chk("rstturn_oen_late", pad_oen[6], 1'b1);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      cfg_we    = ($urandom_range(0, 3) == 0);
      cfg_addr  = AW'($urandom_range(0, 43));
      cfg_wdata = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) filt_len = FW'($urandom_range(0, 15));
      core_out  = {$urandom, $urandom};
      for (int k = 0; k < NP; k++) begin
        if ($urandom_range(0, 7) == 0) pad_in[k] = ~pad_in[k];
        edge_clr[k] = ($urandom_range(0, 7) == 0);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mprj_pad_ctrl.md
# mprj_pad_ctrl

Parametrised, clocked controller for the user-project pad ring. Each pad has its own registered mode word (DM encoding, plus an input-filter enable). The block provides:
- registered pad-cell controls (OEN, REN, I);
- input synchronisation and per-pad glitch filtering;
- sticky edge capture with an interrupt;
- an output-enable turnaround sequence so a pad is never driven during a mode switch.

It sits between the core/housekeeping configuration logic and the bidirectional pad wrappers.

## Interface
Parameters:
- NUM_PADS, 38, number of pads controlled
- ADDR_W, 6, width of config pad index; must satisfy 2**ADDR_W >= NUM_PADS
- FILT_W, 4, width of filter length and per-pad filter counters
- TURN_CYC, 4, cycles from an output-enable write to OEN falling; legal range 1..15

Ports:
- wb_clk_i  in  1  clock; all state on rising edge
- wb_rst_i  in  1  reset, synchronous, active-high
- cfg_we  in  1  config write strobe, accepted only when cfg_ready=1
- cfg_addr  in  ADDR_W  pad index
- cfg_wdata  in  4  {filt_en, dm[2:0]}
- cfg_ready  out  1  high when a write can be accepted
- cfg_err  out  1  one-cycle pulse on an accepted write with cfg_addr >= NUM_PADS
- filt_len  in  FILT_W  global filter length L
- core_out  in  NUM_PADS  data to drive
- core_in  out  NUM_PADS  synchronised, filtered pad input
- pad_in  in  NUM_PADS  from pad cell C
- pad_out  out  NUM_PADS  to pad cell I
- pad_oen  out  NUM_PADS  to pad cell OEN, active-low
- pad_ren  out  NUM_PADS  to pad cell REN, active-low pull-up
- pad_dm  out  3*NUM_PADS  effective DM per pad, pad k at [3k+2:3k]
- edge_clr  in  NUM_PADS  write-1-to-clear sticky edges
- edge_rise  out  NUM_PADS  sticky rising-edge flags
- edge_fall  out  NUM_PADS  sticky falling-edge flags
- irq  out  1  registered OR of all edge_rise and edge_fall bits

## Operation
- DM decode:
  - 001: input; oen=1, ren=1.
  - 010: input with pull-up; oen=1, ren=0.
  - 011: input with pull-down; oen=1, ren=1 (pad cell has no pull-down).
  - 110: output; oen=0 after turnaround, ren=1.
  - Any other value is stored as 001.
- Config write, accepted when cfg_we=1 and cfg_ready=1:
  - Index out of range: nothing changes and cfg_err pulses.
  - Otherwise the pad's dm and filt_en update.
- Writes presented while cfg_ready=0 are dropped silently; no cfg_err.
- Turnaround FSM, states IDLE and TURN:
  - IDLE → TURN on an accepted write that sets dm=110 on a pad whose current dm≠110. cfg_ready drops, the counter is loaded, and that pad's oen stays 1.
  - TURN → IDLE when the counter expires. The target pad's oen falls and cfg_ready rises.
  - Writing 110 to a pad already at 110 updates filt_en only; no TURN.
  - Writing a non-output mode to an output pad: oen rises at the next edge; no wait.
- Input path, per pad:
  - Two-flop synchroniser s2, then filter counter cnt.
  - If s2==core_in: cnt<=0.
  - Else if cnt==Leff: core_in<=s2 and cnt<=0.
  - Else: cnt<=cnt+1.
  - Leff = filt_len when filt_en=1, else 0.
- The input path runs in every mode, so output pads read back their driven value.
- Edges:
  - A core_in 0→1 update sets edge_rise; a 1→0 update sets edge_fall. The flag is set on the same edge core_in updates.
  - If set and edge_clr coincide, set wins.
- pad_out = core_out registered, independent of oen.

## Timing
- Reset values:
  - pad_dm all 001, pad_oen all 1, pad_ren all 1, pad_out 0.
  - core_in 0, synchroniser flops and cnt 0.
  - edge_rise/edge_fall 0, irq 0, cfg_err 0, cfg_ready 1, FSM IDLE.
  - Stored filt_en 0.
- Reset asserted during TURN aborts the turnaround: the pad stays tristated and returns to dm 001.
- pad_in to core_in latency: the change must persist; core_in updates at edge 3+Leff after the change.
- Glitch rule: a pad_in pulse shorter than Leff+1 cycles at s2 never reaches core_in.
- irq follows the edge flags by one cycle.
- Config write sampled at edge N:
  - pad_dm, pad_ren and pad_oen (non-output cases) change at edge N.
  - cfg_err is high for the cycle after edge N.
- Output enable sampled at edge N:
  - pad_dm=110 from edge N.
  - cfg_ready is low from edge N.
  - pad_oen falls and cfg_ready rises at edge N+TURN_CYC.
- core_out to pad_out: 1 cycle.
- cnt saturation is impossible: cnt ≤ Leff ≤ 2**FILT_W−1.
- Changing filt_len mid-count takes effect on the next compare. If cnt > new Leff, it triggers the update at the next compare.

## Test plan
- Reset: hold wb_rst_i 2 cycles → all outputs at the listed reset values; pad_dm = 001 replicated 38 times; cfg_ready=1.
- Filter: write pad 5 {1,001}, filt_len=3.
  - pad_in[5] high 3 cycles then low → core_in[5] stays 0, edge_rise[5]=0.
  - pad_in[5] high 10 cycles → core_in[5]=1 at edge 6 after the rise; edge_rise[5]=1; irq=1 one cycle later.
- Turnaround: TURN_CYC=4; write pad 0 {0,110} at edge N.
  - pad_dm[2:0]=110 at N; pad_oen[0]=1 through N+3, 0 at N+4; cfg_ready low during N..N+3.
  - A write to pad 1 at N+2 is dropped.
- Mode exit and pull-up: pad 0 in output mode; write {0,010} → next edge pad_oen[0]=1, pad_ren[0]=0.
- Errors/illegal: cfg_addr=40 → cfg_err one-cycle pulse, no state change; dm=111 to pad 2 → pad_dm=001.
- Edge clear and reset: edge_clr[5]=1 in the same cycle as a new fall → edge_fall[5]=1 (set wins). Reset asserted at N+2 of a turnaround → pad_oen all 1, cfg_ready=1 after reset.
